tracker_axis_sequencer: RTL and testbench
=========================================

# tracker_axis_sequencer

Two-axis solar-tracker motor sequencer with a parametrised data width. It drives the theta (vertical) and phi (horizontal) motors one axis at a time. In automatic mode it balances photoresistor pairs; in manual mode it servoes to commanded angles, taking the shortest path on phi. Compared with the first-generation controller it adds a per-axis settle filter, direction-reversal dead time, a hold state with hysteresis re-arm, a move timeout fault, and a safe stop on mode change. It sits between the ADC/angle-sensor front end and the motor driver stage.

## Interface
- W, 16: width of all sensor and angle inputs.
- DEADBAND, 5: an error with |err| <= DEADBAND is in-band.
- REARM, 10: in HOLD, a re-seek starts when |err| > REARM on either axis; REARM must be >= DEADBAND.
- HALF_TURN, 180: phi shortest-path threshold, in angle units.
- SETTLE, 4: number of consecutive in-band cycles needed to accept an axis; must be >= 1.
- TIMEOUT, 1000: maximum number of out-of-band cycles in a single MOVE phase.
- clk, in, 1: the single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- mode, in, 1: 1 = manual, 0 = automatic.
- r_v1, r_v2, in, W: vertical photoresistor pair (automatic theta).
- r_h1, r_h2, in, W: horizontal photoresistor pair (automatic phi).
- theta_target, phi_target, in, W: manual set-points.
- theta_actual, phi_actual, in, W: current angles.
- mot_theta, out, 2: theta motor code.
- mot_phi, out, 2: phi motor code.
- active_axis, out, 1: 0 = theta phase, 1 = phi phase.
- aligned, out, 1: high while in HOLD.
- fault, out, 1: high while in FAULT.

## Operation
- Motor codes are 00 = stop, 01 = clockwise, 11 = counter-clockwise. Code 10 is never driven.
- Error arithmetic uses W+1-bit signed values, with no overflow.
- Theta error:
  - Automatic: err = r_v1 − r_v2.
  - Manual: err = theta_actual − theta_target.
- Phi error:
  - Automatic: err = r_h1 − r_h2.
  - Manual: d = phi_actual − phi_target. If |d| <= HALF_TURN then err = d; otherwise err = −d (the reversed, shorter path).
- Direction from err:
  - err > DEADBAND → 01.
  - err < −DEADBAND → 11.
  - Otherwise → in-band.
- Only the axis named by active_axis may be non-zero; the other motor output is always 00.
- State T_MOVE (active_axis = 0), driving theta:
  - Out-of-band: drive the direction code and increment tmo.
  - In-band: mot = 00, go to T_SETTLE with cnt = 0.
  - Requested direction opposite to the code currently driven: mot = 00 for one cycle (dead time), then drive the new direction.
  - tmo reaches TIMEOUT: go to FAULT.
- State T_SETTLE: mot = 00.
  - In-band: cnt increments. The cycle on which cnt == SETTLE−1 and the error is in-band goes to P_MOVE, with tmo cleared.
  - Any out-of-band cycle: return to T_MOVE, with tmo cleared.
- States P_MOVE and P_SETTLE (active_axis = 1) behave identically on phi. P_SETTLE completion goes to HOLD.
- HOLD: both motors 00, aligned = 1. If either axis has |err| > REARM, go to T_MOVE. Errors between DEADBAND and REARM are ignored (hysteresis).
- FAULT: both motors 00, fault = 1. The state persists until reset or a mode change.
- Mode change is detected as mode ≠ mode_q, where mode_q is mode registered on clk. On a mode change, from any state:
  - both motors go to 00;
  - cnt and tmo clear;
  - the next state is T_MOVE.

## Timing
- Reset values: state T_MOVE, mot_theta = 00, mot_phi = 00, active_axis = 0, aligned = 0, fault = 0, cnt = 0, tmo = 0, mode_q = mode level at reset release (sampled on the first edge).
- Reset asserted mid-move forces all outputs to their reset values immediately, without waiting for a clock edge.
- All outputs are registered. Inputs sampled at edge k are reflected on the outputs after edge k; latency is 1 cycle.
- Best-case axis acceptance: the first in-band sample, plus SETTLE in-band cycles, gives SETTLE+1 cycles from the first in-band edge to the next phase.
- Dead time on a direction reversal is exactly 1 cycle of 00.
- FAULT is entered on the edge where the TIMEOUT-th consecutive out-of-band MOVE cycle has been counted.
- Mode change takes priority over all other transitions, including FAULT and the settle-complete transition, on the same edge.

## Test plan
- Reset and automatic theta, defaults: r_v1 = 100, r_v2 = 50 → mot_theta = 01 one cycle after rst_n rises. Set r_v1 = 52 → mot_theta = 00 next cycle, then active_axis = 1 after 5 in-band cycles.
- Manual phi wrap: theta in-band, phi_actual = 10, phi_target = 300 (|d| = 290 > 180) → mot_phi = 01. With phi_target = 100 → mot_phi = 11.
- Reversal: during theta MOVE with err = +20, flip the error to −20 → mot_theta goes 01, then 00 for exactly 1 cycle, then 11.
- Settle glitch and hysteresis:
  - In T_SETTLE, an err = +8 pulse for 1 cycle → returns to T_MOVE, and the settle count restarts.
  - In HOLD, err = 8 → aligned stays 1.
  - In HOLD, err = 11 → T_MOVE on the next edge.
- Timeout: TIMEOUT = 1000, err held at +50 → fault = 1 and both motors 00 after 1000 MOVE cycles. Toggling mode → fault = 0, state T_MOVE.
- Asynchronous reset mid-move: while mot_phi = 11, drop rst_n between clock edges → all outputs at their reset values before the next edge.

Source files
------------

// File: rtl/tracker_axis_sequencer_if.sv
// Sensor/set-point inputs and motor/status outputs of the two-axis tracker sequencer.
interface tracker_axis_sequencer_if #(
    parameter int unsigned W = 16
);
    logic         mode;
    logic [W-1:0] r_v1;
    logic [W-1:0] r_v2;
    logic [W-1:0] r_h1;
    logic [W-1:0] r_h2;
    logic [W-1:0] theta_target;
    logic [W-1:0] phi_target;
    logic [W-1:0] theta_actual;
    logic [W-1:0] phi_actual;
    logic [1:0]   mot_theta;
    logic [1:0]   mot_phi;
    logic         active_axis;
    logic         aligned;
    logic         fault;

    modport master (
        output mode, r_v1, r_v2, r_h1, r_h2, theta_target, phi_target, theta_actual, phi_actual,
        input  mot_theta, mot_phi, active_axis, aligned, fault
    );

    modport slave (
        input  mode, r_v1, r_v2, r_h1, r_h2, theta_target, phi_target, theta_actual, phi_actual,
        output mot_theta, mot_phi, active_axis, aligned, fault
    );
endinterface

// File: rtl/tracker_axis_sequencer.sv
// Solar-tracker motor sequencer: moves theta then phi to balance (auto) or to set-points (manual),
// with per-axis settle filter, reversal dead time, hysteretic hold and a move timeout fault.
module tracker_axis_sequencer #(
    parameter int unsigned W         = 16,
    parameter int unsigned DEADBAND  = 5,
    parameter int unsigned REARM     = 10,
    parameter int unsigned HALF_TURN = 180,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT   = 1000
) (
    input logic                     clk,
    input logic                     rst_n,
    tracker_axis_sequencer_if.slave bus
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [W:0]    DB_L     = (W + 1)'(DEADBAND);
    localparam logic [W:0]    RA_L     = (W + 1)'(REARM);
    localparam logic [W:0]    HT_L     = (W + 1)'(HALF_TURN);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StTMove,
        StTSettle,
        StPMove,
        StPSettle,
        StHold,
        StFault
    } state_e;

    state_e        r_state, w_state_d;
    logic [1:0]    r_mot_t, w_mot_t_d;
    logic [1:0]    r_mot_p, w_mot_p_d;
    logic          r_axis, w_axis_d;
    logic          r_aligned, w_aligned_d;
    logic          r_fault, w_fault_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [TW-1:0] r_tmo, w_tmo_d;
    logic          r_mode_q;
    logic          r_mode_vld;

    logic signed [W:0] w_err_t, w_d_p, w_err_p, w_err_a;
    logic [W:0]        w_mag_t, w_mag_p, w_mag_a;
    logic              w_phi_phase, w_inb, w_rearm, w_mode_chg;
    logic [1:0]        w_cur, w_dir, w_drive;

    function automatic logic [W:0] f_abs(input logic signed [W:0] e);
        return e[W] ? -e : e;
    endfunction

    // Operands are zero-extended to W+1 bits, so the differences never overflow.
    assign w_err_t = bus.mode ? ($signed({1'b0, bus.theta_actual}) - $signed({1'b0, bus.theta_target}))
                              : ($signed({1'b0, bus.r_v1}) - $signed({1'b0, bus.r_v2}));
    assign w_d_p   = bus.mode ? ($signed({1'b0, bus.phi_actual}) - $signed({1'b0, bus.phi_target}))
                              : ($signed({1'b0, bus.r_h1}) - $signed({1'b0, bus.r_h2}));
    assign w_err_p = (bus.mode && (f_abs(w_d_p) > HT_L)) ? -w_d_p : w_d_p;

    assign w_mag_t     = f_abs(w_err_t);
    assign w_mag_p     = f_abs(w_err_p);
    assign w_phi_phase = (r_state == StPMove) || (r_state == StPSettle);
    assign w_err_a     = w_phi_phase ? w_err_p : w_err_t;
    assign w_mag_a     = w_phi_phase ? w_mag_p : w_mag_t;
    assign w_inb       = (w_mag_a <= DB_L);
    assign w_rearm     = (w_mag_t > RA_L) || (w_mag_p > RA_L);
    assign w_mode_chg  = r_mode_vld && (bus.mode != r_mode_q);

    // A requested direction opposite to the one being driven costs one stopped cycle.
    assign w_cur   = w_phi_phase ? r_mot_p : r_mot_t;
    assign w_dir   = w_err_a[W] ? 2'b11 : 2'b01;
    assign w_drive = ((w_cur != 2'b00) && (w_cur != w_dir)) ? 2'b00 : w_dir;

    always_comb begin
        w_state_d   = r_state;
        w_mot_t_d   = 2'b00;
        w_mot_p_d   = 2'b00;
        w_axis_d    = r_axis;
        w_aligned_d = 1'b0;
        w_fault_d   = 1'b0;
        w_cnt_d     = r_cnt;
        w_tmo_d     = r_tmo;
        if (w_mode_chg) begin
            w_state_d = StTMove;
            w_axis_d  = 1'b0;
            w_cnt_d   = '0;
            w_tmo_d   = '0;
        end else begin
            unique case (r_state)
                StTMove, StPMove: begin
                    if (w_inb) begin
                        w_state_d = (r_state == StTMove) ? StTSettle : StPSettle;
                        w_cnt_d   = '0;
                    end else if (r_tmo == TMO_LAST) begin
                        w_state_d = StFault;
                        w_fault_d = 1'b1;
                    end else begin
                        w_tmo_d = r_tmo + TW'(1);
                        if (r_state == StTMove) w_mot_t_d = w_drive;
                        else                    w_mot_p_d = w_drive;
                    end
                end
                StTSettle, StPSettle: begin
                    if (!w_inb) begin
                        w_state_d = (r_state == StTSettle) ? StTMove : StPMove;
                        w_cnt_d   = '0;
                        w_tmo_d   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_cnt_d = '0;
                        w_tmo_d = '0;
                        if (r_state == StTSettle) begin
                            w_state_d = StPMove;
                            w_axis_d  = 1'b1;
                        end else begin
                            w_state_d   = StHold;
                            w_aligned_d = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                StHold: begin
                    if (w_rearm) begin
                        w_state_d = StTMove;
                        w_axis_d  = 1'b0;
                        w_cnt_d   = '0;
                        w_tmo_d   = '0;
                    end else begin
                        w_aligned_d = 1'b1;
                    end
                end
                StFault: w_fault_d = 1'b1;
                default: w_state_d = StTMove;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StTMove;
            r_mot_t    <= 2'b00;
            r_mot_p    <= 2'b00;
            r_axis     <= 1'b0;
            r_aligned  <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_mode_q   <= 1'b0;
            r_mode_vld <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_mot_t    <= w_mot_t_d;
            r_mot_p    <= w_mot_p_d;
            r_axis     <= w_axis_d;
            r_aligned  <= w_aligned_d;
            r_fault    <= w_fault_d;
            r_cnt      <= w_cnt_d;
            r_tmo      <= w_tmo_d;
            r_mode_q   <= bus.mode;
            r_mode_vld <= 1'b1;
        end
    end

    assign bus.mot_theta   = r_mot_t;
    assign bus.mot_phi     = r_mot_p;
    assign bus.active_axis = r_axis;
    assign bus.aligned     = r_aligned;
    assign bus.fault       = r_fault;
endmodule

// File: tb/tb_tracker_axis_sequencer.sv
// Directed scenarios plus randomized run against an integer-level model of the tracker sequencer.
module tb_tracker_axis_sequencer;
    localparam int W         = 16;
    localparam int DEADBAND  = 5;
    localparam int REARM     = 10;
    localparam int HALF_TURN = 180;
    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 1000;

    localparam int STG_MOVE   = 0;
    localparam int STG_SETTLE = 1;
    localparam int STG_HOLD   = 2;
    localparam int STG_FAULT  = 3;

    logic clk;
    logic rst_n;
    int   chk;
    int   errs;

    tracker_axis_sequencer_if #(.W(W)) bus ();

    tracker_axis_sequencer #(
        .W(W), .DEADBAND(DEADBAND), .REARM(REARM), .HALF_TURN(HALF_TURN),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: stage/axis of the sequence, settle run length, timeout count, last motor codes.
    int   m_stage, m_axis, m_run, m_tmo;
    int   m_mot [2];
    bit   m_seen;
    logic m_mode;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_stage = STG_MOVE; m_axis = 0; m_run = 0; m_tmo = 0;
        m_mot[0] = 0; m_mot[1] = 0; m_seen = 1'b0;
    endtask

    task automatic model_edge();
        int et, ep, e, want, prev;
        bit chg;
        et = bus.mode ? int'(bus.theta_actual) - int'(bus.theta_target)
                      : int'(bus.r_v1) - int'(bus.r_v2);
        if (bus.mode) begin
            ep = int'(bus.phi_actual) - int'(bus.phi_target);
            if (iabs(ep) > HALF_TURN) ep = -ep;
        end else begin
            ep = int'(bus.r_h1) - int'(bus.r_h2);
        end
        chg    = m_seen && (bus.mode != m_mode);
        m_mode = bus.mode;
        m_seen = 1'b1;
        prev   = m_mot[m_axis];
        m_mot[0] = 0;
        m_mot[1] = 0;
        e = (m_axis == 1) ? ep : et;
        if (chg) begin
            m_stage = STG_MOVE; m_axis = 0; m_run = 0; m_tmo = 0;
        end else if (m_stage == STG_MOVE) begin
            if (iabs(e) <= DEADBAND) begin
                m_stage = STG_SETTLE; m_run = 0;
            end else begin
                m_tmo++;
                if (m_tmo >= TIMEOUT) m_stage = STG_FAULT;
                else begin
                    want = (e > 0) ? 1 : 3;
                    m_mot[m_axis] = (prev != 0 && prev != want) ? 0 : want;
                end
            end
        end else if (m_stage == STG_SETTLE) begin
            if (iabs(e) > DEADBAND) begin
                m_stage = STG_MOVE; m_tmo = 0;
            end else begin
                m_run++;
                if (m_run == SETTLE) begin
                    m_run = 0; m_tmo = 0;
                    if (m_axis == 0) begin m_axis = 1; m_stage = STG_MOVE; end
                    else m_stage = STG_HOLD;
                end
            end
        end else if (m_stage == STG_HOLD) begin
            if (iabs(et) > REARM || iabs(ep) > REARM) begin
                m_stage = STG_MOVE; m_axis = 0; m_run = 0; m_tmo = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.r_v1 = '0; bus.r_v2 = '0; bus.r_h1 = '0; bus.r_h2 = '0;
        bus.theta_target = '0; bus.theta_actual = '0; bus.phi_target = '0; bus.phi_actual = '0;
    endtask

    task automatic do_reset(input logic m);
        rst_n = 1'b0;
        bus.mode = m;
        zero_inputs();
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.mode = 1'b0;
        zero_inputs();
        bus.r_v1 = 100; bus.r_v2 = 50;
        model_reset();
        rst_n = 1'b1; #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk++; if ({bus.mot_theta, bus.mot_phi} !== 4'b0000) begin
            errs++; $display("FAIL reset_motors got %b/%b want 00/00", bus.mot_theta, bus.mot_phi); end
        chk++; if ({bus.active_axis, bus.aligned, bus.fault} !== 3'b000) begin
            errs++; $display("FAIL reset_flags got ax/al/f=%b want 000",
                             {bus.active_axis, bus.aligned, bus.fault}); end
        #3 rst_n = 1'b1;
        tick();
        chk++; if (bus.mot_theta !== 2'b01) begin
            errs++; $display("FAIL auto_theta_cw got %b want 01", bus.mot_theta); end
        chk++; if (bus.mot_phi !== 2'b00) begin
            errs++; $display("FAIL auto_phi_idle got %b want 00", bus.mot_phi); end
        bus.r_v1 = 52;
        tick();
        chk++; if (bus.mot_theta !== 2'b00) begin
            errs++; $display("FAIL auto_theta_inband got %b want 00", bus.mot_theta); end
        repeat (3) tick();
        chk++; if (bus.active_axis !== 1'b0) begin
            errs++; $display("FAIL settle_early got %b want 0", bus.active_axis); end
        tick();
        chk++; if (bus.active_axis !== 1'b1) begin
            errs++; $display("FAIL settle_done got %b want 1", bus.active_axis); end
    endtask

    task automatic test_phi_wrap();
        do_reset(1'b1);
        bus.theta_actual = 50; bus.theta_target = 50;
        bus.phi_actual = 10; bus.phi_target = 300;
        repeat (5) tick();
        chk++; if (bus.active_axis !== 1'b1) begin
            errs++; $display("FAIL manual_theta_accept got %b want 1", bus.active_axis); end
        tick();
        chk++; if (bus.mot_phi !== 2'b01 || bus.mot_theta !== 2'b00) begin
            errs++; $display("FAIL phi_wrap_short got %b/%b want 00/01", bus.mot_theta, bus.mot_phi); end
        bus.phi_target = 100;
        tick();
        chk++; if (bus.mot_phi !== 2'b00) begin
            errs++; $display("FAIL phi_reverse_dead got %b want 00", bus.mot_phi); end
        tick();
        chk++; if (bus.mot_phi !== 2'b11) begin
            errs++; $display("FAIL phi_direct_ccw got %b want 11", bus.mot_phi); end
    endtask

    task automatic test_async_reset();
        chk++; if (bus.mot_phi !== 2'b11) begin
            errs++; $display("FAIL async_pre got %b want 11", bus.mot_phi); end
        #2 rst_n = 1'b0;
        #1;
        chk++; if ({bus.mot_theta, bus.mot_phi} !== 4'b0000) begin
            errs++; $display("FAIL async_motors got %b/%b want 00/00", bus.mot_theta, bus.mot_phi); end
        chk++; if ({bus.active_axis, bus.aligned, bus.fault} !== 3'b000) begin
            errs++; $display("FAIL async_flags got %b want 000",
                             {bus.active_axis, bus.aligned, bus.fault}); end
        model_reset();
    endtask

    task automatic test_reversal();
        do_reset(1'b0);
        bus.r_v1 = 120; bus.r_v2 = 100;
        tick();
        chk++; if (bus.mot_theta !== 2'b01) begin
            errs++; $display("FAIL rev_start got %b want 01", bus.mot_theta); end
        bus.r_v1 = 80;
        tick();
        chk++; if (bus.mot_theta !== 2'b00) begin
            errs++; $display("FAIL rev_dead got %b want 00", bus.mot_theta); end
        tick();
        chk++; if (bus.mot_theta !== 2'b11) begin
            errs++; $display("FAIL rev_new got %b want 11", bus.mot_theta); end
        tick();
        chk++; if (bus.mot_theta !== 2'b11) begin
            errs++; $display("FAIL rev_hold got %b want 11", bus.mot_theta); end
    endtask

    task automatic test_settle_glitch();
        do_reset(1'b0);
        bus.r_v1 = 100; bus.r_v2 = 100; bus.r_h1 = 200; bus.r_h2 = 200;
        repeat (2) tick();
        bus.r_v1 = 108;
        tick();
        chk++; if (bus.mot_theta !== 2'b00 || bus.active_axis !== 1'b0) begin
            errs++; $display("FAIL glitch_stop got mt=%b ax=%b want 00/0", bus.mot_theta,
                             bus.active_axis); end
        bus.r_v1 = 100;
        repeat (4) tick();
        chk++; if (bus.active_axis !== 1'b0) begin
            errs++; $display("FAIL glitch_restart got %b want 0", bus.active_axis); end
        tick();
        chk++; if (bus.active_axis !== 1'b1) begin
            errs++; $display("FAIL glitch_accept got %b want 1", bus.active_axis); end
        repeat (4) tick();
        chk++; if (bus.aligned !== 1'b0) begin
            errs++; $display("FAIL hold_early got %b want 0", bus.aligned); end
        tick();
        chk++; if (bus.aligned !== 1'b1) begin
            errs++; $display("FAIL hold_enter got %b want 1", bus.aligned); end
        bus.r_v1 = 108;
        repeat (3) tick();
        chk++; if (bus.aligned !== 1'b1 || {bus.mot_theta, bus.mot_phi} !== 4'b0000) begin
            errs++; $display("FAIL hyst_keep got al=%b mot=%b want 1/0000", bus.aligned,
                             {bus.mot_theta, bus.mot_phi}); end
        bus.r_v1 = 111;
        tick();
        chk++; if (bus.aligned !== 1'b0 || bus.active_axis !== 1'b0) begin
            errs++; $display("FAIL rearm got al=%b ax=%b want 0/0", bus.aligned, bus.active_axis); end
        tick();
        chk++; if (bus.mot_theta !== 2'b01) begin
            errs++; $display("FAIL rearm_move got %b want 01", bus.mot_theta); end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        bus.r_v1 = 150; bus.r_v2 = 100;
        repeat (TIMEOUT - 1) tick();
        chk++; if (bus.fault !== 1'b0 || bus.mot_theta !== 2'b01) begin
            errs++; $display("FAIL tmo_before got f=%b mt=%b want 0/01", bus.fault, bus.mot_theta); end
        tick();
        chk++; if (bus.fault !== 1'b1 || {bus.mot_theta, bus.mot_phi} !== 4'b0000) begin
            errs++; $display("FAIL tmo_fault got f=%b mot=%b want 1/0000", bus.fault,
                             {bus.mot_theta, bus.mot_phi}); end
        tick();
        chk++; if (bus.fault !== 1'b1) begin
            errs++; $display("FAIL tmo_sticky got %b want 1", bus.fault); end
        bus.mode = 1'b1; bus.theta_actual = 30; bus.theta_target = 0;
        tick();
        chk++; if (bus.fault !== 1'b0 || bus.active_axis !== 1'b0 || bus.mot_theta !== 2'b00) begin
            errs++; $display("FAIL mode_clear got f=%b ax=%b mt=%b want 0/0/00", bus.fault,
                             bus.active_axis, bus.mot_theta); end
        tick();
        chk++; if (bus.mot_theta !== 2'b01) begin
            errs++; $display("FAIL mode_move got %b want 01", bus.mot_theta); end
    endtask

    function automatic int pick_delta();
        case ($urandom_range(0, 13))
            0, 1, 2, 3, 4: return 0;
            5:             return 3;
            6:             return -5;
            7:             return 6;
            8:             return -8;
            9:             return 10;
            10:            return -11;
            11:            return 20;
            12:            return -40;
            default:       return 250;
        endcase
    endfunction

    task automatic test_random();
        logic [1:0] e_mt, e_mp;
        logic       e_al, e_f;
        do_reset(1'b0);
        bus.r_v1 = 500; bus.r_v2 = 500; bus.r_h1 = 700; bus.r_h2 = 700;
        bus.theta_target = 90; bus.theta_actual = 90; bus.phi_target = 0; bus.phi_actual = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.r_v1 = W'(500 + pick_delta());
            if ($urandom_range(0, 7) == 0) bus.r_h1 = W'(700 + pick_delta());
            if ($urandom_range(0, 7) == 0) bus.theta_actual = W'(90 + pick_delta());
            if ($urandom_range(0, 7) == 0) begin
                bus.phi_actual = W'($urandom_range(0, 359));
                bus.phi_target = W'((int'(bus.phi_actual) + pick_delta() + 360) % 360);
            end
            if ($urandom_range(0, 299) == 0) bus.mode = ~bus.mode;
            tick();
            e_mt = 2'(m_mot[0]);
            e_mp = 2'(m_mot[1]);
            e_al = (m_stage == STG_HOLD);
            e_f  = (m_stage == STG_FAULT);
            chk++;
            if (bus.mot_theta !== e_mt || bus.mot_phi !== e_mp || bus.aligned !== e_al ||
                bus.fault !== e_f ||
                (m_stage < STG_HOLD && bus.active_axis !== 1'(m_axis))) begin
                errs++;
                $display("FAIL random cycle %0d got mt=%b mp=%b ax=%b al=%b f=%b want mt=%b mp=%b ax=%0d al=%b f=%b",
                         i, bus.mot_theta, bus.mot_phi, bus.active_axis, bus.aligned, bus.fault,
                         e_mt, e_mp, m_axis, e_al, e_f);
            end
        end
    endtask

    initial begin
        chk  = 0;
        errs = 0;
        test_reset();
        test_phi_wrap();
        test_async_reset();
        test_reversal();
        test_settle_glitch();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end
endmodule
